// File: rtl/sequence_playback_pkg.sv
// Shared definitions for the tile-sequence blocks: sizes, tile codes, FSM
// states and the helpers that unpack a tile from the packed sequence word.
package sequence_playback_pkg;

   localparam int SEQ_LEN_MAX = 9;
   localparam int SEQ_W       = 2 * SEQ_LEN_MAX;

   localparam logic [1:0] TILE0 = 2'd0;
   localparam logic [1:0] TILE1 = 2'd1;
   localparam logic [1:0] TILE2 = 2'd2;
   localparam logic [1:0] TILE3 = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHOW   = 2'd1,
      ST_GAP    = 2'd2,
      ST_FINISH = 2'd3
   } play_state_t;

   // Tile idx sits at bits {2idx, 2idx+1}, with the lower-numbered bit as MSB.
   function automatic logic [1:0] get_tile(input logic [SEQ_W-1:0] seq,
                                           input logic [5:0] idx);
      logic [5:0]       bit_pos;
      logic [SEQ_W-1:0] shifted;
      bit_pos = {idx[4:0], 1'b0};
      shifted = seq >> bit_pos;
      return {shifted[0], shifted[1]};
   endfunction

   function automatic logic [3:0] tile_to_onehot(input logic [1:0] tile);
      logic [3:0] onehot;
      case (tile)
         TILE0:   onehot = 4'b0001;
         TILE1:   onehot = 4'b0010;
         TILE2:   onehot = 4'b0100;
         TILE3:   onehot = 4'b1000;
         default: onehot = 4'b0000;
      endcase
      return onehot;
   endfunction

endpackage

// File: rtl/sequence_playback_timer.sv
// Loadable down-counter used for both the lit and blank dwell periods;
// expired is high once the count has reached zero.
module playback_timer #(
   parameter int TIMER_W = 25
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               load,
   input  logic [TIMER_W-1:0] load_value,
   input  logic               enable,
   output logic               expired
);

   logic [TIMER_W-1:0] count_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_value;
      end else if (enable && (count_reg != '0)) begin
         count_reg <= count_reg - 1'b1;
      end
   end

   assign expired = (count_reg == '0);

endmodule

// File: rtl/sequence_playback.sv
// Replays the latched tile sequence on the tile LEDs: each tile lit for
// ON_CYCLES, then blanked for OFF_CYCLES, with a one-cycle done pulse at the end.
module sequence_playback
   import sequence_playback_pkg::*;
#(
   parameter int ON_CYCLES  = 25000000,
   parameter int OFF_CYCLES = 12500000,
   parameter int TIMER_W    = 25
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [SEQ_W-1:0] seq,
   input  logic [5:0]       play_len,
   output logic [3:0]       tile_onehot,
   output logic             tile_valid,
   output logic [1:0]       tile_index,
   output logic [5:0]       play_counter,
   output logic             busy,
   output logic             done
);

   localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
   localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);

   play_state_t        state_reg, state_next;
   logic [SEQ_W-1:0]   seq_reg, seq_next;
   logic [5:0]         len_reg, len_next;
   logic [5:0]         cnt_reg, cnt_next;
   logic [5:0]         len_clamped;
   logic [1:0]         tile_next;
   logic               timer_load, timer_enable, timer_expired;
   logic [TIMER_W-1:0] timer_value;

   logic [3:0] tile_onehot_reg;
   logic       tile_valid_reg;
   logic [1:0] tile_index_reg;
   logic       busy_reg;
   logic       done_reg;

   assign len_clamped = (play_len > 6'(SEQ_LEN_MAX)) ? 6'(SEQ_LEN_MAX) : play_len;

   playback_timer #(.TIMER_W(TIMER_W)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (timer_load),
      .load_value (timer_value),
      .enable     (timer_enable),
      .expired    (timer_expired)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg <= ST_IDLE;
         seq_reg   <= '0;
         len_reg   <= '0;
         cnt_reg   <= '0;
      end else begin
         state_reg <= state_next;
         seq_reg   <= seq_next;
         len_reg   <= len_next;
         cnt_reg   <= cnt_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      seq_next     = seq_reg;
      len_next     = len_reg;
      cnt_next     = cnt_reg;
      timer_load   = 1'b0;
      timer_enable = 1'b0;
      timer_value  = '0;
      case (state_reg)
         ST_IDLE: begin
            if (start) begin
               seq_next = seq;
               len_next = len_clamped;
               cnt_next = '0;
               if (len_clamped != '0) begin
                  state_next  = ST_SHOW;
                  timer_load  = 1'b1;
                  timer_value = ON_LOAD;
               end else begin
                  state_next = ST_FINISH;
               end
            end
         end
         ST_SHOW: begin
            timer_enable = 1'b1;
            if (timer_expired) begin
               state_next  = ST_GAP;
               timer_load  = 1'b1;
               timer_value = OFF_LOAD;
            end
         end
         ST_GAP: begin
            timer_enable = 1'b1;
            if (timer_expired) begin
               if (cnt_reg == len_reg - 6'd1) begin
                  state_next = ST_FINISH;
               end else begin
                  state_next  = ST_SHOW;
                  cnt_next    = cnt_reg + 6'd1;
                  timer_load  = 1'b1;
                  timer_value = ON_LOAD;
               end
            end
         end
         ST_FINISH: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Outputs are registered from the next-state values so the first tile
   // appears in the cycle right after start is accepted.
   assign tile_next = get_tile(seq_next, cnt_next);

   always_ff @(posedge clk) begin
      if (reset) begin
         tile_onehot_reg <= '0;
         tile_valid_reg  <= 1'b0;
         tile_index_reg  <= TILE0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
      end else begin
         tile_valid_reg  <= (state_next == ST_SHOW);
         tile_onehot_reg <= (state_next == ST_SHOW) ? tile_to_onehot(tile_next) : 4'b0000;
         tile_index_reg  <= (state_next == ST_SHOW) ? tile_next : TILE0;
         busy_reg        <= (state_next == ST_SHOW) || (state_next == ST_GAP);
         done_reg        <= (state_next == ST_FINISH);
      end
   end

   assign tile_onehot  = tile_onehot_reg;
   assign tile_valid   = tile_valid_reg;
   assign tile_index   = tile_index_reg;
   assign play_counter = cnt_reg;
   assign busy         = busy_reg;
   assign done         = done_reg;

endmodule

// File: tb/tb_sequence_playback.sv
// Scoreboard bench: each accepted start pushes the expected per-cycle output
// trace, which is popped and compared one cycle at a time after every edge.
module tb_sequence_playback;

   localparam int ON  = 4;
   localparam int OFF = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [17:0] seq;
   logic [5:0]  play_len;
   logic [3:0]  tile_onehot;
   logic        tile_valid;
   logic [1:0]  tile_index;
   logic [5:0]  play_counter;
   logic        busy;
   logic        done;

   logic [14:0] exp_q[$];
   logic [5:0]  last_cnt;
   int          checks;
   int          failures;
   int          cyc;

   always #5 clk = ~clk;

   sequence_playback #(.ON_CYCLES(ON), .OFF_CYCLES(OFF), .TIMER_W(3)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .seq          (seq),
      .play_len     (play_len),
      .tile_onehot  (tile_onehot),
      .tile_valid   (tile_valid),
      .tile_index   (tile_index),
      .play_counter (play_counter),
      .busy         (busy),
      .done         (done)
   );

   function automatic logic [14:0] rec(input logic [3:0] oh, input logic v,
                                       input logic [1:0] idx, input logic [5:0] cnt,
                                       input logic b, input logic d);
      return {oh, v, idx, cnt, b, d};
   endfunction

   task automatic check(input string tag, input logic [31:0] observed,
                        input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic push_play(input logic [17:0] s, input int len);
      int n;
      n = (len > 9) ? 9 : len;
      for (int i = 0; i < n; i++) begin
         logic [1:0] t;
         logic [3:0] oh;
         t  = {s[2*i], s[2*i+1]};
         oh = 4'b0001 << t;
         for (int j = 0; j < ON; j++)  exp_q.push_back(rec(oh, 1'b1, t, 6'(i), 1'b1, 1'b0));
         for (int j = 0; j < OFF; j++) exp_q.push_back(rec(4'b0, 1'b0, 2'b0, 6'(i), 1'b1, 1'b0));
      end
      last_cnt = (n == 0) ? 6'd0 : 6'(n - 1);
      exp_q.push_back(rec(4'b0, 1'b0, 2'b0, last_cnt, 1'b0, 1'b1));
   endtask

   task automatic tick();
      logic [14:0] e;
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = rec(4'b0, 1'b0, 2'b0, last_cnt, 1'b0, 1'b0);
      check($sformatf("cyc%0d", cyc),
            32'({tile_onehot, tile_valid, tile_index, play_counter, busy, done}), 32'(e));
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic begin_play(input logic [17:0] s, input logic [5:0] len);
      seq      = s;
      play_len = len;
      start    = 1'b1;
      push_play(s, int'(len));
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      cyc      = 0;
      last_cnt = 6'd0;
      reset    = 1'b1;
      start    = 1'b0;
      seq      = '0;
      play_len = '0;
      $display("scenario reset");
      run(2);
      reset = 1'b0;
      run(1);

      $display("scenario three tiles seq=00013 len=3");
      begin_play(18'h00013, 6'd3);
      tick();
      start = 1'b0;
      run(20);

      $display("scenario zero length");
      begin_play(18'h00013, 6'd0);
      tick();
      start = 1'b0;
      run(3);

      $display("scenario clamped length 20 seq=3FFFF");
      begin_play(18'h3FFFF, 6'd20);
      tick();
      start = 1'b0;
      run(57);

      $display("scenario ignored restart and input changes");
      begin_play(18'h00013, 6'd3);
      tick();
      start = 1'b0;
      tick();
      seq      = 18'h3FFFF;
      play_len = 6'd9;
      run(3);
      start = 1'b1;
      tick();
      start = 1'b0;
      run(15);

      $display("scenario reset mid playback");
      begin_play(18'h00013, 6'd3);
      tick();
      start = 1'b0;
      run(7);
      reset = 1'b1;
      exp_q.delete();
      last_cnt = 6'd0;
      tick();
      reset = 1'b0;
      run(2);
      begin_play(18'h00013, 6'd3);
      tick();
      start = 1'b0;
      run(20);

      $display("scenario start held high");
      begin_play(18'h00013, 6'd3);
      exp_q.push_back(rec(4'b0, 1'b0, 2'b0, 6'd2, 1'b0, 1'b0));
      push_play(18'h00013, 3);
      run(21);
      start = 1'b0;
      run(21);

      check("drain", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
